// File: rtl/hispi_stim_pkg.sv
// Shared types and constants for the HiSPi stimulus controller: FSM encoding,
// configuration register map, timing field width and the frame-counter helper.
package hispi_stim_pkg;

    localparam int TIM_W = 12;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_STOP = 2'd3
    } stim_state_e;

    localparam logic [2:0] ADDR_ACT_W = 3'd0;
    localparam logic [2:0] ADDR_BLK_W = 3'd1;
    localparam logic [2:0] ADDR_ACT_H = 3'd2;
    localparam logic [2:0] ADDR_BLK_H = 3'd3;
    localparam logic [2:0] ADDR_MSB   = 3'd4;

    // Frame counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

endpackage

// File: rtl/hispi_stim_if.sv
// Command, configuration and status bundle between a host/datapath and the
// stimulus controller. The controller uses the slave modport.
interface hispi_stim_if;
    import hispi_stim_pkg::*;

    logic             cfg_we;
    logic [2:0]       cfg_addr;
    logic [TIM_W-1:0] cfg_wdata;
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] frame_tgt;
    logic             frame_end;
    logic [TIM_W-1:0] vd_active_width;
    logic [TIM_W-1:0] vd_blank_width;
    logic [TIM_W-1:0] vd_active_height;
    logic [TIM_W-1:0] vd_blank_height;
    logic             ail_msb_1st;
    logic             stim_en;
    logic             busy;
    logic             done;
    logic             cfg_err;
    logic [CNT_W-1:0] frame_cnt;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, start, stop, frame_tgt, frame_end,
        input  vd_active_width, vd_blank_width, vd_active_height, vd_blank_height,
        input  ail_msb_1st, stim_en, busy, done, cfg_err, frame_cnt
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, start, stop, frame_tgt, frame_end,
        output vd_active_width, vd_blank_width, vd_active_height, vd_blank_height,
        output ail_msb_1st, stim_en, busy, done, cfg_err, frame_cnt
    );

endinterface

// File: rtl/hispi_stim_cfg_regs.sv
// Host-writable staging registers. They are always writable; the controller
// decides when their contents are copied into the shadow outputs.
module hispi_stim_cfg_regs
    import hispi_stim_pkg::*;
#(
    parameter int DEF_ACT_W = 16,
    parameter int DEF_BLK_W = 8,
    parameter int DEF_ACT_H = 4,
    parameter int DEF_BLK_H = 2
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [TIM_W-1:0] cfg_wdata,
    output logic [TIM_W-1:0] stg_act_w_r,
    output logic [TIM_W-1:0] stg_blk_w_r,
    output logic [TIM_W-1:0] stg_act_h_r,
    output logic [TIM_W-1:0] stg_blk_h_r,
    output logic             stg_msb_1st_r,
    output logic             bad_wr_s
);

    assign bad_wr_s = cfg_we && (cfg_addr > ADDR_MSB);

    // Address decode and staging register update.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            stg_act_w_r   <= TIM_W'(DEF_ACT_W);
            stg_blk_w_r   <= TIM_W'(DEF_BLK_W);
            stg_act_h_r   <= TIM_W'(DEF_ACT_H);
            stg_blk_h_r   <= TIM_W'(DEF_BLK_H);
            stg_msb_1st_r <= 1'b0;
        end else if (cfg_we) begin
            case (cfg_addr)
                ADDR_ACT_W: stg_act_w_r   <= cfg_wdata;
                ADDR_BLK_W: stg_blk_w_r   <= cfg_wdata;
                ADDR_ACT_H: stg_act_h_r   <= cfg_wdata;
                ADDR_BLK_H: stg_blk_h_r   <= cfg_wdata;
                ADDR_MSB:   stg_msb_1st_r <= cfg_wdata[0];
                default:    stg_msb_1st_r <= stg_msb_1st_r;
            endcase
        end
    end

endmodule

// File: rtl/hispi_stim_ctrl.sv
// HiSPi stimulus run controller: sequences frame runs, owns the shadow timing
// copy seen by the datapath and reloads it only on frame boundaries.
module hispi_stim_ctrl
    import hispi_stim_pkg::*;
#(
    parameter int DEF_ACT_W = 16,
    parameter int DEF_BLK_W = 8,
    parameter int DEF_ACT_H = 4,
    parameter int DEF_BLK_H = 2
) (
    input  logic        sclk,
    input  logic        rst,
    hispi_stim_if.slave bus
);

    stim_state_e      state_r, next_state_s;
    logic [TIM_W-1:0] stg_act_w_s, stg_blk_w_s, stg_act_h_s, stg_blk_h_s;
    logic             stg_msb_1st_s, bad_wr_s;
    logic [TIM_W-1:0] shd_act_w_r, shd_blk_w_r, shd_act_h_r, shd_blk_h_r;
    logic             shd_msb_1st_r;
    logic [CNT_W-1:0] frame_cnt_r, frame_tgt_r, cnt_inc_s;
    logic             stop_pend_r, stim_en_r, busy_r, done_r, cfg_err_r;
    logic             stg_ok_s, start_ok_s, start_rej_s, load_shadow_s;

    hispi_stim_cfg_regs #(
        .DEF_ACT_W(DEF_ACT_W), .DEF_BLK_W(DEF_BLK_W),
        .DEF_ACT_H(DEF_ACT_H), .DEF_BLK_H(DEF_BLK_H)
    ) u_cfg_regs (
        .sclk         (sclk),
        .rst          (rst),
        .cfg_we       (bus.cfg_we),
        .cfg_addr     (bus.cfg_addr),
        .cfg_wdata    (bus.cfg_wdata),
        .stg_act_w_r  (stg_act_w_s),
        .stg_blk_w_r  (stg_blk_w_s),
        .stg_act_h_r  (stg_act_h_s),
        .stg_blk_h_r  (stg_blk_h_s),
        .stg_msb_1st_r(stg_msb_1st_s),
        .bad_wr_s     (bad_wr_s)
    );

    assign stg_ok_s  = (stg_act_w_s != 12'd0) && (stg_blk_w_s != 12'd0) &&
                       (stg_act_h_s != 12'd0) && (stg_blk_h_s != 12'd0);
    assign cnt_inc_s = sat_inc(frame_cnt_r);

    // Next-state decode. A stop seen on the terminating frame_end itself also ends the run.
    always_comb begin
        next_state_s  = state_r;
        start_ok_s    = 1'b0;
        start_rej_s   = 1'b0;
        load_shadow_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start && stg_ok_s) begin
                    next_state_s = ST_LOAD;
                    start_ok_s   = 1'b1;
                end else if (bus.start) begin
                    start_rej_s  = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                next_state_s  = ST_RUN;
                load_shadow_s = 1'b1;
            end
            ST_RUN: begin
                if (bus.frame_end) begin
                    load_shadow_s = 1'b1;
                    if (((frame_tgt_r != 8'd0) && (cnt_inc_s == frame_tgt_r)) ||
                        stop_pend_r || bus.stop) begin
                        next_state_s = ST_STOP;
                    end else begin
                        next_state_s = ST_RUN;
                    end
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_STOP: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State, run bookkeeping and registered status outputs.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            frame_cnt_r <= 8'd0;
            frame_tgt_r <= 8'd0;
            stop_pend_r <= 1'b0;
            stim_en_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            cfg_err_r   <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            stim_en_r <= (next_state_s == ST_RUN);
            busy_r    <= (next_state_s != ST_IDLE);
            done_r    <= (next_state_s == ST_STOP);
            cfg_err_r <= bad_wr_s || start_rej_s;
            if (start_ok_s) begin
                frame_tgt_r <= bus.frame_tgt;
            end
            if (state_r == ST_LOAD) begin
                frame_cnt_r <= 8'd0;
            end else if ((state_r == ST_RUN) && bus.frame_end) begin
                frame_cnt_r <= cnt_inc_s;
            end
            if (state_r == ST_STOP) begin
                stop_pend_r <= 1'b0;
            end else if ((state_r == ST_RUN) && bus.stop) begin
                stop_pend_r <= 1'b1;
            end
        end
    end

    // Shadow copy; a same-edge staging write lands one boundary later.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            shd_act_w_r   <= TIM_W'(DEF_ACT_W);
            shd_blk_w_r   <= TIM_W'(DEF_BLK_W);
            shd_act_h_r   <= TIM_W'(DEF_ACT_H);
            shd_blk_h_r   <= TIM_W'(DEF_BLK_H);
            shd_msb_1st_r <= 1'b0;
        end else if (load_shadow_s) begin
            shd_act_w_r   <= stg_act_w_s;
            shd_blk_w_r   <= stg_blk_w_s;
            shd_act_h_r   <= stg_act_h_s;
            shd_blk_h_r   <= stg_blk_h_s;
            shd_msb_1st_r <= stg_msb_1st_s;
        end
    end

    assign bus.vd_active_width  = shd_act_w_r;
    assign bus.vd_blank_width   = shd_blk_w_r;
    assign bus.vd_active_height = shd_act_h_r;
    assign bus.vd_blank_height  = shd_blk_h_r;
    assign bus.ail_msb_1st      = shd_msb_1st_r;
    assign bus.stim_en          = stim_en_r;
    assign bus.busy             = busy_r;
    assign bus.done             = done_r;
    assign bus.cfg_err          = cfg_err_r;
    assign bus.frame_cnt        = frame_cnt_r;

endmodule

// File: tb/tb_hispi_stim_ctrl.sv
// Directed bench for hispi_stim_ctrl: run sequencing, stop handling, shadow
// reload timing, start rejection and asynchronous reset.
module tb_hispi_stim_ctrl;
    import hispi_stim_pkg::*;

    logic sclk = 1'b0;
    logic rst  = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    hispi_stim_if bus ();

    hispi_stim_ctrl dut (.sclk(sclk), .rst(rst), .bus(bus));

    always #5 sclk = ~sclk;

    task automatic tick;
        @(posedge sclk);
        #1;
    endtask

    task automatic wcfg(input logic [2:0] a, input logic [11:0] d);
        bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
        tick;
        bus.cfg_we = 1'b0;
    endtask

    task automatic pulse_fe;
        bus.frame_end = 1'b1;
        tick;
        bus.frame_end = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] tgt);
        bus.frame_tgt = tgt; bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        n_tests++;
        if (bus.stim_en !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cfg_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_status: en/busy/done/err=%b%b%b%b want 0000", bus.stim_en, bus.busy, bus.done, bus.cfg_err);
        end
        n_tests++;
        if (bus.frame_cnt !== 8'd0 || bus.ail_msb_1st !== 1'b0) begin
            n_fail++; $display("FAIL reset_cnt: cnt=%0d msb=%b want 0/0", bus.frame_cnt, bus.ail_msb_1st);
        end
        n_tests++;
        if (bus.vd_active_width !== 12'd16 || bus.vd_blank_width !== 12'd8 ||
            bus.vd_active_height !== 12'd4 || bus.vd_blank_height !== 12'd2) begin
            n_fail++; $display("FAIL reset_shadow: %0d/%0d/%0d/%0d want 16/8/4/2", bus.vd_active_width,
                               bus.vd_blank_width, bus.vd_active_height, bus.vd_blank_height);
        end
    endtask

    task automatic test_single_frame;
        int bad = 0;
        do_start(8'd1);
        n_tests++;
        if (bus.busy !== 1'b1 || bus.stim_en !== 1'b0) begin
            n_fail++; $display("FAIL sf_load: busy=%b en=%b want 1/0", bus.busy, bus.stim_en);
        end
        tick;
        n_tests++;
        if (bus.stim_en !== 1'b1) begin
            n_fail++; $display("FAIL sf_en_rise: en=%b want 1", bus.stim_en);
        end
        repeat (38) begin
            tick;
            if (bus.stim_en !== 1'b1) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL sf_en_hold: %0d low cycles want 0", bad);
        end
        pulse_fe;
        n_tests++;
        if (bus.done !== 1'b1 || bus.frame_cnt !== 8'd1 || bus.stim_en !== 1'b0) begin
            n_fail++; $display("FAIL sf_done: done=%b cnt=%0d en=%b want 1/1/0", bus.done, bus.frame_cnt, bus.stim_en);
        end
        tick;
        n_tests++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL sf_idle: done=%b busy=%b want 0/0", bus.done, bus.busy);
        end
    endtask

    task automatic test_stop_mid;
        int low = 0;
        int extra_done = 0;
        do_start(8'd0);
        tick;
        for (int f = 1; f <= 3; f++) begin
            if (f == 3) begin
                repeat (4) begin tick; if (bus.stim_en !== 1'b1) low++; end
                bus.stop = 1'b1; tick; bus.stop = 1'b0;
                repeat (4) begin tick; if (bus.stim_en !== 1'b1) low++; end
            end else begin
                repeat (9) begin tick; if (bus.stim_en !== 1'b1) low++; end
            end
            pulse_fe;
            if (f < 3) begin
                n_tests++;
                if (bus.stim_en !== 1'b1 || bus.frame_cnt !== 8'(f)) begin
                    n_fail++; $display("FAIL stop_frame%0d: en=%b cnt=%0d want 1/%0d", f, bus.stim_en, bus.frame_cnt, f);
                end
            end
        end
        n_tests++;
        if (low != 0) begin
            n_fail++; $display("FAIL stop_en_hold: %0d low cycles want 0", low);
        end
        n_tests++;
        if (bus.done !== 1'b1 || bus.stim_en !== 1'b0 || bus.frame_cnt !== 8'd3) begin
            n_fail++; $display("FAIL stop_end: done=%b en=%b cnt=%0d want 1/0/3", bus.done, bus.stim_en, bus.frame_cnt);
        end
        repeat (4) begin tick; if (bus.done === 1'b1) extra_done++; end
        n_tests++;
        if (extra_done != 0) begin
            n_fail++; $display("FAIL stop_one_done: %0d extra done cycles want 0", extra_done);
        end
        pulse_fe;
        bus.stop = 1'b1; tick; bus.stop = 1'b0;
        n_tests++;
        if (bus.frame_cnt !== 8'd3 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_ignore: cnt=%0d busy=%b want 3/0", bus.frame_cnt, bus.busy);
        end
    endtask

    task automatic test_cfg_update;
        wcfg(ADDR_MSB, 12'd1);
        n_tests++;
        if (bus.ail_msb_1st !== 1'b0) begin
            n_fail++; $display("FAIL msb_idle: msb=%b want 0", bus.ail_msb_1st);
        end
        do_start(8'd2);
        tick;
        n_tests++;
        if (bus.ail_msb_1st !== 1'b1 || bus.vd_active_width !== 12'd16) begin
            n_fail++; $display("FAIL cfg_load: msb=%b aw=%0d want 1/16", bus.ail_msb_1st, bus.vd_active_width);
        end
        repeat (3) tick;
        bus.frame_tgt = 8'd1; bus.start = 1'b1; tick; bus.start = 1'b0;
        wcfg(ADDR_ACT_W, 12'd100);
        n_tests++;
        if (bus.vd_active_width !== 12'd16) begin
            n_fail++; $display("FAIL cfg_mid: aw=%0d want 16", bus.vd_active_width);
        end
        repeat (3) tick;
        pulse_fe;
        n_tests++;
        if (bus.vd_active_width !== 12'd100 || bus.frame_cnt !== 8'd1 || bus.stim_en !== 1'b1) begin
            n_fail++; $display("FAIL cfg_boundary: aw=%0d cnt=%0d en=%b want 100/1/1", bus.vd_active_width, bus.frame_cnt, bus.stim_en);
        end
        repeat (5) tick;
        pulse_fe;
        n_tests++;
        if (bus.done !== 1'b1 || bus.frame_cnt !== 8'd2) begin
            n_fail++; $display("FAIL cfg_tgt2: done=%b cnt=%0d want 1/2", bus.done, bus.frame_cnt);
        end
        tick;
    endtask

    task automatic test_collision;
        do_start(8'd0);
        tick;
        repeat (5) tick;
        bus.cfg_we = 1'b1; bus.cfg_addr = ADDR_ACT_W; bus.cfg_wdata = 12'd200; bus.frame_end = 1'b1;
        tick;
        bus.cfg_we = 1'b0; bus.frame_end = 1'b0;
        n_tests++;
        if (bus.vd_active_width !== 12'd100 || bus.frame_cnt !== 8'd1) begin
            n_fail++; $display("FAIL coll_same_edge: aw=%0d cnt=%0d want 100/1", bus.vd_active_width, bus.frame_cnt);
        end
        repeat (3) tick;
        bus.stop = 1'b1; tick; bus.stop = 1'b0;
        repeat (3) tick;
        pulse_fe;
        n_tests++;
        if (bus.vd_active_width !== 12'd200 || bus.done !== 1'b1) begin
            n_fail++; $display("FAIL coll_next: aw=%0d done=%b want 200/1", bus.vd_active_width, bus.done);
        end
        tick;
    endtask

    task automatic test_zero_reject;
        wcfg(ADDR_BLK_H, 12'd0);
        n_tests++;
        if (bus.cfg_err !== 1'b0) begin
            n_fail++; $display("FAIL zr_write: err=%b want 0", bus.cfg_err);
        end
        do_start(8'd1);
        n_tests++;
        if (bus.cfg_err !== 1'b1 || bus.busy !== 1'b0 || bus.stim_en !== 1'b0) begin
            n_fail++; $display("FAIL zr_reject: err=%b busy=%b en=%b want 1/0/0", bus.cfg_err, bus.busy, bus.stim_en);
        end
        tick;
        n_tests++;
        if (bus.cfg_err !== 1'b0 || bus.busy !== 1'b0 || bus.stim_en !== 1'b0) begin
            n_fail++; $display("FAIL zr_pulse: err=%b busy=%b en=%b want 0/0/0", bus.cfg_err, bus.busy, bus.stim_en);
        end
        wcfg(3'd5, 12'd7);
        n_tests++;
        if (bus.cfg_err !== 1'b1) begin
            n_fail++; $display("FAIL bad_addr: err=%b want 1", bus.cfg_err);
        end
        tick;
        n_tests++;
        if (bus.cfg_err !== 1'b0) begin
            n_fail++; $display("FAIL bad_addr_pulse: err=%b want 0", bus.cfg_err);
        end
        wcfg(ADDR_BLK_H, 12'd2);
    endtask

    task automatic test_reset_mid;
        do_start(8'd0);
        tick;
        repeat (4) tick; pulse_fe;
        repeat (4) tick; pulse_fe;
        repeat (3) tick;
        n_tests++;
        if (bus.frame_cnt !== 8'd2 || bus.stim_en !== 1'b1) begin
            n_fail++; $display("FAIL rm_pre: cnt=%0d en=%b want 2/1", bus.frame_cnt, bus.stim_en);
        end
        #2 rst = 1'b1;
        #1;
        test_reset;
        tick;
        rst = 1'b0;
        tick;
        do_start(8'd1);
        tick;
        n_tests++;
        if (bus.vd_active_width !== 12'd16 || bus.stim_en !== 1'b1) begin
            n_fail++; $display("FAIL rm_staging: aw=%0d en=%b want 16/1", bus.vd_active_width, bus.stim_en);
        end
    endtask

    initial begin
        bus.cfg_we = 1'b0; bus.cfg_addr = 3'd0; bus.cfg_wdata = 12'd0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.frame_tgt = 8'd0; bus.frame_end = 1'b0;
        repeat (3) @(posedge sclk);
        #1;
        test_reset;
        rst = 1'b0;
        repeat (6) tick;
        test_single_frame;
        tick;
        test_stop_mid;
        test_cfg_update;
        test_collision;
        test_zero_reject;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hispi_stim_ctrl.md
HISPI_STIM_CTRL -- requirements
Module: hispi_stim_ctrl

Interface
REQ-001 SHALL have parameter DEF_ACT_W, default 16, reset value of active-width staging and shadow registers.
REQ-002 SHALL have parameter DEF_BLK_W, default 8, reset value of blank-width registers.
REQ-003 SHALL have parameter DEF_ACT_H, default 4, reset value of active-height registers.
REQ-004 SHALL have parameter DEF_BLK_H, default 2, reset value of blank-height registers.
REQ-005 SHALL have port sclk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port cfg_we, input, 1, staging-register write strobe.
REQ-008 SHALL have port cfg_addr, input, 3, register select: 0 act_w, 1 blk_w, 2 act_h, 3 blk_h, 4 msb_1st (bit 0).
REQ-009 SHALL have port cfg_wdata, input, 12, write data.
REQ-010 SHALL have ports start and stop, input, 1 each, single-cycle command pulses.
REQ-011 SHALL have port frame_tgt, input, 8, frames to run (0 = continuous); sampled on accepted start.
REQ-012 SHALL have port frame_end, input, 1, datapath pulse at the end of the last active line.
REQ-013 SHALL have ports vd_active_width, vd_blank_width, vd_active_height, vd_blank_height, output, 12 each, shadow timing to the stimulus datapath.
REQ-014 SHALL have port ail_msb_1st, output, 1, shadow bit-order select.
REQ-015 SHALL have port stim_en, output, 1, datapath run enable.
REQ-016 SHALL have ports busy, done, cfg_err, output, 1 each; frame_cnt, output, 8.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, RUN, STOP.
REQ-018 SHALL write cfg_wdata into the addressed staging register on cfg_we in any state.
REQ-019 SHALL ignore writes to addresses 5-7 and pulse cfg_err for one cycle.
REQ-020 SHALL accept start only in IDLE when all four staging timing values are nonzero. An accepted start goes to LOAD and latches frame_tgt.
REQ-021 SHALL reject a start in IDLE that sees any zero staging timing value. It stays in IDLE and pulses cfg_err for one cycle.
REQ-022 SHALL in LOAD copy all staging registers to the shadow outputs, clear frame_cnt, and go to RUN after one cycle.
REQ-023 SHALL assert stim_en exactly while in RUN. With start sampled at edge k, stim_en is high after edge k+1.
REQ-024 SHALL on frame_end in RUN increment frame_cnt, saturating at 255, and reload the shadows from staging on the same edge.
REQ-025 SHALL on a frame_end in RUN go to STOP if the incremented count equals a nonzero latched target, or if a stop is pending.
REQ-026 SHALL on stop in RUN set stop_pending. The stop takes effect at the next frame_end, never mid-frame.
REQ-027 SHALL ignore stop in IDLE, LOAD and STOP, and ignore start outside IDLE.
REQ-028 SHALL in STOP deassert stim_en, pulse done for one cycle, clear stop_pending, and return to IDLE next cycle.
REQ-029 SHALL give the old staging value to the shadow when cfg_we and a shadow load (LOAD or frame_end) occur on the same edge. The new value applies at the next boundary.
REQ-030 SHALL assert busy in every state except IDLE.
REQ-031 SHALL ignore frame_end outside RUN.
REQ-032 SHALL hold frame_cnt after STOP until the next LOAD.

Reset
REQ-033 SHALL on rst, at any time including mid-frame, immediately force the following values:
- state IDLE;
- stim_en, busy, done, cfg_err = 0;
- stop_pending = 0;
- frame_cnt = 0, latched target = 0;
- staging and shadow timing registers = DEF_* values;
- ail_msb_1st = 0.

Structure
REQ-034 SHALL take the state encoding, the register address constants and the 12-bit timing width from shared package hispi_stim_pkg.
REQ-035 SHALL place the staging registers and address decode in one sub-module hispi_stim_cfg_regs; the FSM and shadows stay in the top module.

Verification
REQ-036 SHALL verify single-frame run:
- Stimulus: defaults, frame_tgt=1, start at cycle 10, frame_end at cycle 50.
- Response: stim_en high from cycle 12; frame_cnt=1; done pulse at cycle 51; idle at cycle 52.
REQ-037 SHALL verify a stop request mid-frame:
- Stimulus: frame_tgt=0; stop pulse 5 cycles before the 3rd frame_end.
- Response: stim_en stays high until the 3rd frame_end; frame_cnt=3; one done pulse.
REQ-038 SHALL verify a config update during a run:
- Stimulus: write act_w=100 mid-frame 1.
- Response: vd_active_width stays 16 until frame_end, then reads 100.
REQ-039 SHALL verify a same-edge collision:
- Stimulus: write act_w=200 on the same edge as a frame_end.
- Response: shadow is unchanged at that boundary and reads 200 after the next frame_end.
REQ-040 SHALL verify zero-value rejection:
- Stimulus: write blk_h=0, then start.
- Response: cfg_err one-cycle pulse; busy stays 0; stim_en stays 0.
REQ-041 SHALL verify reset mid-frame:
- Stimulus: assert rst while in RUN with frame_cnt=2.
- Response: stim_en=0 and frame_cnt=0 with no clock edge; shadows read 16/8/4/2.
